// File: rtl/riscv_pkg.sv
// Shared widths, arbiter state encoding and starvation defaults for the
// data-memory path.
package riscv_pkg;

  localparam int ALEN = 32;
  localparam int XLEN = 32;

  // Default number of consecutive denied cycles before M1 is forced to win.
  localparam int STARVE_LIMIT_DEFAULT = 4;
  // Width of the starvation counter; STARVE_LIMIT must fit in it.
  localparam int STARVE_CW = 8;

  typedef enum logic [0:0] {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Bundle of the two requester ports and the data-memory side of the arbiter.
//
// Handshake: a port presents req with stable we/funct3/addr/wdata (and lock on
// M1) until the cycle it sees gnt; req && gnt in one cycle is the accept.
// Reads answer with rvalid for exactly one cycle, one cycle after the accept;
// rdata keeps its last value otherwise. There is no backpressure on responses.
interface data_mem_arbiter_if;
  import riscv_pkg::*;

  logic            m0_req;
  logic            m0_we;
  logic [2:0]      m0_funct3;
  logic [ALEN-1:0] m0_addr;
  logic [XLEN-1:0] m0_wdata;
  logic            m0_gnt;
  logic            m0_rvalid;
  logic [XLEN-1:0] m0_rdata;

  logic            m1_req;
  logic            m1_we;
  logic [2:0]      m1_funct3;
  logic [ALEN-1:0] m1_addr;
  logic [XLEN-1:0] m1_wdata;
  logic            m1_lock;
  logic            m1_gnt;
  logic            m1_rvalid;
  logic [XLEN-1:0] m1_rdata;

  logic            mem_we;
  logic [2:0]      mem_funct3;
  logic [ALEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] mem_rdata;

  // Arbiter side.
  modport slave (
    input  m0_req, m0_we, m0_funct3, m0_addr, m0_wdata,
    output m0_gnt, m0_rvalid, m0_rdata,
    input  m1_req, m1_we, m1_funct3, m1_addr, m1_wdata, m1_lock,
    output m1_gnt, m1_rvalid, m1_rdata,
    output mem_we, mem_funct3, mem_addr, mem_wdata,
    input  mem_rdata
  );

  // Requesters plus memory side.
  modport master (
    output m0_req, m0_we, m0_funct3, m0_addr, m0_wdata,
    input  m0_gnt, m0_rvalid, m0_rdata,
    output m1_req, m1_we, m1_funct3, m1_addr, m1_wdata, m1_lock,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  mem_we, mem_funct3, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/arb_starve_counter.sv
// Saturating count of consecutive cycles M1 has been left waiting.
module arb_starve_counter #(
  parameter int LIMIT = 4,
  parameter int CW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          clr,
  output logic [CW-1:0] cnt,
  output logic          at_limit
);

  assign at_limit = (cnt == CW'(LIMIT));

  // Clear wins over increment; the count sticks once it reaches LIMIT.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && !at_limit) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter in front of the data memory: M0 (CPU load/store) normally
// wins, M1 (loader/debug) gets a forced win after STARVE_LIMIT denied cycles
// and may hold the memory with m1_lock. Addresses pass through untouched.
module data_mem_arbiter
  import riscv_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  data_mem_arbiter_if.slave    bus,
  output arb_state_t           dbg_state,
  output logic [STARVE_CW-1:0] dbg_starve_cnt
);

  arb_state_t           state;
  logic                 gnt0;
  logic                 gnt1;
  logic                 lock_hold;
  logic                 starve_inc;
  logic                 at_limit;
  logic [STARVE_CW-1:0] starve_cnt;
  logic                 rsp_vld;
  logic                 rsp_m1;
  logic [XLEN-1:0]      rdata0_q;
  logic [XLEN-1:0]      rdata1_q;

  // M1 keeps the memory while it is locked and still asking with lock set.
  assign lock_hold = (state == LOCKED) && bus.m1_req && bus.m1_lock;

  // Grant selection: locked owner first, then M0 priority unless M1 is starved.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (lock_hold) begin
        gnt1 = 1'b1;
      end else if (bus.m0_req && bus.m1_req) begin
        if (at_limit) gnt1 = 1'b1;
        else          gnt0 = 1'b1;
      end else begin
        gnt0 = bus.m0_req;
        gnt1 = bus.m1_req;
      end
    end
  end

  assign bus.m0_gnt = gnt0;
  assign bus.m1_gnt = gnt1;

  // Memory command mux; M0's fields are parked on the bus when idle.
  assign bus.mem_we     = gnt1 ? bus.m1_we     : (gnt0 & bus.m0_we);
  assign bus.mem_funct3 = gnt1 ? bus.m1_funct3 : bus.m0_funct3;
  assign bus.mem_addr   = gnt1 ? bus.m1_addr   : bus.m0_addr;
  assign bus.mem_wdata  = gnt1 ? bus.m1_wdata  : bus.m0_wdata;

  // Any cycle M1 is not waiting (idle or granted) resets its starvation count.
  assign starve_inc = bus.m1_req && !gnt1;

  arb_starve_counter #(
    .LIMIT (STARVE_LIMIT),
    .CW    (STARVE_CW)
  ) u_starve (
    .clk      (clk),
    .rst      (rst),
    .inc      (starve_inc),
    .clr      (!starve_inc),
    .cnt      (starve_cnt),
    .at_limit (at_limit)
  );

  // Ownership FSM plus the one-cycle read response path with its port tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ARB;
      rsp_vld  <= 1'b0;
      rsp_m1   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      case (state)
        ARB:     if (gnt1 && bus.m1_lock) state <= LOCKED;
        LOCKED:  if (!(bus.m1_req && bus.m1_lock)) state <= ARB;
        default: state <= ARB;
      endcase
      rsp_vld <= (gnt0 && !bus.m0_we) || (gnt1 && !bus.m1_we);
      rsp_m1  <= gnt1;
      if (gnt0 && !bus.m0_we) rdata0_q <= bus.mem_rdata;
      if (gnt1 && !bus.m1_we) rdata1_q <= bus.mem_rdata;
    end
  end

  assign bus.m0_rvalid = rsp_vld && !rsp_m1;
  assign bus.m1_rvalid = rsp_vld && rsp_m1;
  assign bus.m0_rdata  = rdata0_q;
  assign bus.m1_rdata  = rdata1_q;

  assign dbg_state      = state;
  assign dbg_starve_cnt = starve_cnt;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed scenarios followed by random traffic, all compared cycle by cycle
// against a transaction-level model of the arbiter and a reference memory.
module tb_data_mem_arbiter;
  import riscv_pkg::*;

  localparam int LIMIT = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic mem_clr;
  always #5 clk = ~clk;

  data_mem_arbiter_if bus ();
  arb_state_t           dbg_state;
  logic [STARVE_CW-1:0] dbg_starve_cnt;

  data_mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .dbg_state      (dbg_state),
    .dbg_starve_cnt (dbg_starve_cnt)
  );

  // ---------------- memory environment ----------------
  function automatic logic [31:0] init_word(input logic [7:0] idx);
    if (idx == 8'd64) return 32'h1122_3344;
    return {idx, 24'h0} ^ (32'(idx) * 32'h9E37_79B9);
  endfunction

  logic [31:0] env_mem [256];
  logic        env_wr  [256];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) env_wr[i] <= 1'b0;
    end else if (bus.mem_we) begin
      env_mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
      env_wr[bus.mem_addr[9:2]]  <= 1'b1;
    end
  end

  assign bus.mem_rdata = env_wr[bus.mem_addr[9:2]] ? env_mem[bus.mem_addr[9:2]]
                                                   : init_word(bus.mem_addr[9:2]);

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [256];
  bit          m_locked;
  int          m_starve;
  logic        exp_rv0, exp_rv1;
  logic [31:0] exp_rd0, exp_rd1;
  logic        g0, g1;
  logic        obs_m0_gnt, obs_m1_gnt;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_locked = 1'b0;
    m_starve = 0;
    exp_rv0  = 1'b0;
    exp_rv1  = 1'b0;
    exp_rd0  = '0;
    exp_rd1  = '0;
  endtask

  // One clock: check everything mid-cycle, then advance the model at the edge.
  task automatic run_cycle();
    logic [7:0] i0, i1;
    @(negedge clk);
    g0 = 1'b0;
    g1 = 1'b0;
    if (!rst) begin
      if (m_locked && bus.m1_req && bus.m1_lock) g1 = 1'b1;
      else if (bus.m0_req && bus.m1_req) begin
        if (m_starve == LIMIT) g1 = 1'b1;
        else                   g0 = 1'b1;
      end else begin
        g0 = bus.m0_req;
        g1 = bus.m1_req;
      end
    end
    obs_m0_gnt = bus.m0_gnt;
    obs_m1_gnt = bus.m1_gnt;
    chk("m0_gnt", bus.m0_gnt, g0);
    chk("m1_gnt", bus.m1_gnt, g1);
    chk("mem_we", bus.mem_we, g1 ? bus.m1_we : (g0 ? bus.m0_we : 1'b0));
    chk("mem_addr", bus.mem_addr, g1 ? bus.m1_addr : bus.m0_addr);
    chk("mem_wdata", bus.mem_wdata, g1 ? bus.m1_wdata : bus.m0_wdata);
    chk("mem_funct3", bus.mem_funct3, g1 ? bus.m1_funct3 : bus.m0_funct3);
    chk("m0_rvalid", bus.m0_rvalid, exp_rv0);
    chk("m1_rvalid", bus.m1_rvalid, exp_rv1);
    chk("m0_rdata", bus.m0_rdata, exp_rd0);
    chk("m1_rdata", bus.m1_rdata, exp_rd1);
    chk("state", dbg_state, m_locked ? 32'd1 : 32'd0);
    chk("starve_cnt", dbg_starve_cnt, m_starve);
    @(posedge clk);
    i0 = bus.m0_addr[9:2];
    i1 = bus.m1_addr[9:2];
    if (rst) begin
      model_reset();
    end else begin
      exp_rv0 = g0 && !bus.m0_we;
      exp_rv1 = g1 && !bus.m1_we;
      if (exp_rv0) exp_rd0 = ref_mem[i0];
      if (exp_rv1) exp_rd1 = ref_mem[i1];
      if (g0 && bus.m0_we) ref_mem[i0] = bus.m0_wdata;
      if (g1 && bus.m1_we) ref_mem[i1] = bus.m1_wdata;
      if (bus.m1_req && !g1) m_starve = (m_starve < LIMIT) ? m_starve + 1 : LIMIT;
      else                   m_starve = 0;
      m_locked = g1 && bus.m1_lock;
    end
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_m0(input logic req, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata);
    bus.m0_req    = req;
    bus.m0_we     = we;
    bus.m0_funct3 = 3'b010;
    bus.m0_addr   = addr;
    bus.m0_wdata  = wdata;
  endtask

  task automatic drive_m1(input logic req, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic lock);
    bus.m1_req    = req;
    bus.m1_we     = we;
    bus.m1_funct3 = 3'b010;
    bus.m1_addr   = addr;
    bus.m1_wdata  = wdata;
    bus.m1_lock   = lock;
  endtask

  function automatic logic [31:0] rand_addr();
    return {22'h0, 8'($urandom_range(0, 255)), 2'b00};
  endfunction

  task automatic rand_m0();
    drive_m0($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
    bus.m0_funct3 = 3'($urandom_range(0, 7));
  endtask

  task automatic rand_m1();
    drive_m1($urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)), rand_addr(), $urandom,
             $urandom_range(0, 2) == 0);
    bus.m1_funct3 = 3'($urandom_range(0, 7));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(8'(i));
    rst     = 1'b1;
    mem_clr = 1'b1;
    drive_m0(1'b0, 1'b0, '0, '0);
    drive_m1(1'b0, 1'b0, '0, '0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    mem_clr = 1'b0;
    model_reset();

    // Reset state, with grants held off while rst is high.
    drive_m0(1'b1, 1'b0, 32'h100, '0);
    run_cycle();
    rst = 1'b0;

    // Lone M0 read of 0x100.
    run_cycle();
    chk("req030_gnt", obs_m0_gnt, 1'b1);
    drive_m0(1'b0, 1'b0, 32'h100, '0);
    chk("req030_rdata", bus.m0_rdata, 32'h1122_3344);
    chk("req030_m1_rvalid", bus.m1_rvalid, 1'b0);
    run_cycle();

    // Both requesting without lock: four M0 wins, then one M1 win, repeating.
    drive_m0(1'b1, 1'b0, 32'h010, '0);
    drive_m1(1'b1, 1'b0, 32'h020, '0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      run_cycle();
      chk("req031_m1_gnt", obs_m1_gnt, (i % 5) == 4);
      chk("req031_m0_gnt", obs_m0_gnt, (i % 5) != 4);
    end
    drive_m0(1'b0, 1'b0, '0, '0);
    drive_m1(1'b0, 1'b0, '0, '0, 1'b0);
    run_cycle();

    // M1 locked for three transfers while M0 waits; M0 wins once lock drops.
    drive_m1(1'b1, 1'b0, 32'h040, '0, 1'b1);
    run_cycle();
    chk("req032_lock0", obs_m1_gnt, 1'b1);
    drive_m0(1'b1, 1'b1, 32'h044, 32'h5555_AAAA);
    for (int i = 1; i < 3; i++) begin
      run_cycle();
      chk("req032_lock_m1", obs_m1_gnt, 1'b1);
      chk("req032_lock_m0", obs_m0_gnt, 1'b0);
    end
    chk("req032_state", dbg_state, LOCKED);
    bus.m1_lock = 1'b0;
    run_cycle();
    chk("req032_release", obs_m0_gnt, 1'b1);
    drive_m0(1'b0, 1'b0, '0, '0);
    run_cycle();
    drive_m1(1'b0, 1'b0, '0, '0, 1'b0);
    run_cycle();

    // M0 store beats M1 load to the same word; M1 then reads the new value.
    drive_m0(1'b1, 1'b1, 32'h200, 32'hDEAD_BEEF);
    drive_m1(1'b1, 1'b0, 32'h200, '0, 1'b0);
    run_cycle();
    chk("req033_sw_gnt", obs_m0_gnt, 1'b1);
    drive_m0(1'b0, 1'b0, '0, '0);
    run_cycle();
    chk("req033_lw_gnt", obs_m1_gnt, 1'b1);
    drive_m1(1'b0, 1'b0, '0, '0, 1'b0);
    chk("req033_rdata", bus.m1_rdata, 32'hDEAD_BEEF);
    chk("req033_rvalid", bus.m1_rvalid, 1'b1);
    run_cycle();

    // Reset in the cycle an M1 read (and an M0 write) would be accepted.
    drive_m1(1'b1, 1'b0, 32'h200, '0, 1'b1);
    drive_m0(1'b1, 1'b1, 32'h300, 32'h1234_5678);
    rst = 1'b1;
    run_cycle();
    rst = 1'b0;
    drive_m0(1'b0, 1'b0, '0, '0);
    drive_m1(1'b0, 1'b0, '0, '0, 1'b0);
    chk("req034_m1_rvalid", bus.m1_rvalid, 1'b0);
    chk("req034_m1_rdata", bus.m1_rdata, 32'h0);
    chk("req034_state", dbg_state, ARB);
    chk("req034_starve", dbg_starve_cnt, 32'h0);
    run_cycle();

    // Random traffic; a port only changes its request after being granted.
    rand_m0();
    rand_m1();
    for (int n = 0; n < 500; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      run_cycle();
      if (g0 || !bus.m0_req) rand_m0();
      if (g1 || !bus.m1_req) rand_m1();
    end
    rst = 1'b0;
    drive_m0(1'b0, 1'b0, '0, '0);
    drive_m1(1'b0, 1'b0, '0, '0, 1'b0);
    run_cycle();
    run_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
